// File: rtl/seg_shift_ctrl_if.sv
// Bus between the segment decoder side and the serial display controller.
// The controller takes the slave modport; the decoder/board side takes master.
interface seg_shift_ctrl_if;
    logic [63:0] seg_txt;
    logic        update;
    logic        seg_clk;
    logic        seg_sout;
    logic        seg_pen;
    logic        seg_clrn;
    logic        busy;
    logic        done;
    logic        flash;

    modport master (
        output seg_txt, update,
        input  seg_clk, seg_sout, seg_pen, seg_clrn, busy, done, flash
    );

    modport slave (
        input  seg_txt, update,
        output seg_clk, seg_sout, seg_pen, seg_clrn, busy, done, flash
    );
endinterface

// File: rtl/seg_shift_ctrl.sv
// Shifts the 64-bit seven-segment image LSB first into the board shift-register chain,
// re-sending whenever the image changes or a refresh is requested; also makes the blink signal.
module seg_shift_ctrl #(
    parameter int unsigned HALF       = 2,
    parameter int unsigned BLINK_BITS = 24
) (
    input logic             clk,
    input logic             rst_n,
    seg_shift_ctrl_if.slave disp
);
    localparam int unsigned       PhaseW    = $clog2(2 * HALF);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(2 * HALF - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [63:0]           shadow_q, shadow_d;
    logic [63:0]           last_q, last_d;
    logic [5:0]            bit_q, bit_d;
    logic [PhaseW-1:0]     phase_q, phase_d;
    logic                  dirty_q, dirty_d;
    logic                  seg_clk_q, seg_clk_d;
    logic                  seg_sout_q, seg_sout_d;
    logic                  seg_pen_q, seg_pen_d;
    logic                  seg_clrn_q;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [BLINK_BITS-1:0] blink_q;

    logic              trigger;
    logic              bit_end;
    logic              frame_end;
    logic [PhaseW-1:0] phase_inc;
    logic [5:0]        bit_inc;

    assign phase_inc = phase_q + 1'b1;
    assign bit_inc   = bit_q + 6'd1;
    assign bit_end   = (phase_q == PhaseLast);
    assign frame_end = bit_end && (bit_q == 6'd63);
    // seg_clrn_q gates the trigger so the chain clear lifts one edge before the first frame
    assign trigger   = seg_clrn_q && (disp.update || (disp.seg_txt != last_q) || dirty_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shadow_q   <= '0;
            last_q     <= '0;
            bit_q      <= '0;
            phase_q    <= '0;
            dirty_q    <= 1'b1;
            seg_clk_q  <= 1'b0;
            seg_sout_q <= 1'b0;
            seg_pen_q  <= 1'b0;
            seg_clrn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            blink_q    <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            last_q     <= last_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            dirty_q    <= dirty_d;
            seg_clk_q  <= seg_clk_d;
            seg_sout_q <= seg_sout_d;
            seg_pen_q  <= seg_pen_d;
            seg_clrn_q <= 1'b1;
            busy_q     <= busy_d;
            done_q     <= done_d;
            blink_q    <= blink_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trigger) state_d = StShift;
            StShift: if (frame_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shadow_d   = shadow_q;
        last_d     = last_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        dirty_d    = dirty_q;
        seg_clk_d  = seg_clk_q;
        seg_sout_d = seg_sout_q;
        seg_pen_d  = seg_pen_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    shadow_d   = disp.seg_txt;
                    bit_d      = '0;
                    phase_d    = '0;
                    dirty_d    = 1'b0;
                    seg_sout_d = disp.seg_txt[0];
                    seg_clk_d  = 1'b0;
                    seg_pen_d  = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StShift: begin
                if (!bit_end) begin
                    phase_d   = phase_inc;
                    seg_clk_d = (32'(phase_inc) >= HALF);
                end else if (frame_end) begin
                    phase_d   = '0;
                    seg_clk_d = 1'b0;
                    seg_pen_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    last_d    = shadow_q;
                end else begin
                    phase_d    = '0;
                    bit_d      = bit_inc;
                    seg_clk_d  = 1'b0;
                    seg_sout_d = shadow_q[bit_inc];
                end
            end
            default: ;
        endcase
    end

    assign disp.seg_clk  = seg_clk_q;
    assign disp.seg_sout = seg_sout_q;
    assign disp.seg_pen  = seg_pen_q;
    assign disp.seg_clrn = seg_clrn_q;
    assign disp.busy     = busy_q;
    assign disp.done     = done_q;
    assign disp.flash    = blink_q[BLINK_BITS-1];
endmodule

// File: tb/tb_seg_shift_ctrl.sv
// Directed bench for seg_shift_ctrl: expected serial bits are queued when a frame is provoked
// and checked at every seg_clk rising edge by a monitor.
module tb_seg_shift_ctrl;
    localparam int unsigned Half        = 2;
    localparam int unsigned BlinkBits   = 4;
    localparam int          FrameCycles = 128 * Half;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg_shift_ctrl_if disp ();

    seg_shift_ctrl #(
        .HALF       (Half),
        .BLINK_BITS (BlinkBits)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (disp)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc_now  = 0;
    int   rises    = 0;
    int   dones    = 0;
    bit   exp_q[$];
    bit   mon_exp;
    logic prev_sclk = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc_now++;
        end
    endtask

    task automatic push_frame(input logic [63:0] d);
        for (int i = 0; i < 64; i++) exp_q.push_back(d[i]);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (disp.done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check("done_seen", disp.done, 1);
    endtask

    // Monitor: on each seg_clk rising edge the chain captures seg_sout
    always @(negedge clk) begin
        if (disp.seg_clk === 1'b1 && prev_sclk === 1'b0) begin
            rises++;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL sout_unexpected_bit observed=%0b expected=none", disp.seg_sout);
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                assert (disp.seg_sout === mon_exp) else begin
                    failures++;
                    $error("FAIL sout_bit%0d observed=%0b expected=%0b", rises, disp.seg_sout,
                           mon_exp);
                end
            end
        end
        if (disp.done === 1'b1) dones++;
        prev_sclk = disp.seg_clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a_txt;
        logic [63:0] b_txt;
        logic [63:0] c_txt;
        int          busy_start;
        int          rise_base;
        int          done_base;

        a_txt = 64'h0123_4567_89AB_CDEF;
        b_txt = 64'hF0E1_D2C3_B4A5_9687;
        c_txt = 64'hDEAD_BEEF_0BAD_F00D;
        disp.seg_txt = 64'h0;
        disp.update  = 1'b0;
        busy_start   = 0;

        // Reset state
        step(3);
        check("rst_seg_clk", disp.seg_clk, 0);
        check("rst_seg_sout", disp.seg_sout, 0);
        check("rst_seg_pen", disp.seg_pen, 0);
        check("rst_seg_clrn", disp.seg_clrn, 0);
        check("rst_busy", disp.busy, 0);
        check("rst_done", disp.done, 0);
        check("rst_flash", disp.flash, 0);

        // Release: clear lifts first, then the dirty frame of zeros; flash period 16
        push_frame(64'h0);
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step(1);
            check($sformatf("flash_n%0d", n), disp.flash, ((n % 16) >= 8) ? 1 : 0);
            if (n == 1) begin
                check("rel_clrn_e1", disp.seg_clrn, 1);
                check("rel_busy_e1", disp.busy, 0);
            end
            if (n == 2) begin
                check("rel_busy_e2", disp.busy, 1);
                check("rel_pen_e2", disp.seg_pen, 0);
                busy_start = cyc_now;
            end
        end
        wait_done(FrameCycles + 20);
        check("f0_busy_len", cyc_now - busy_start, FrameCycles);
        check("f0_busy_off", disp.busy, 0);
        check("f0_pen_on", disp.seg_pen, 1);
        check("f0_clk_low", disp.seg_clk, 0);
        step(1);
        check("f0_done_width", disp.done, 0);
        check("f0_no_retrigger", disp.busy, 0);
        check("f0_rises", rises, 64);
        check("f0_dones", dones, 1);
        check("f0_queue_empty", exp_q.size(), 0);

        // End bits set: first and last rising edges carry 1
        rise_base = rises;
        disp.seg_txt = 64'h8000_0000_0000_0001;
        push_frame(disp.seg_txt);
        step(1);
        check("f1_busy", disp.busy, 1);
        wait_done(FrameCycles + 20);
        step(1);
        check("f1_rises", rises - rise_base, 64);
        check("f1_queue_empty", exp_q.size(), 0);

        // Image change mid-frame: A finishes intact, B follows one cycle after done
        disp.seg_txt = a_txt;
        push_frame(a_txt);
        step(1);
        check("f2_busy", disp.busy, 1);
        step(99);
        disp.seg_txt = b_txt;
        push_frame(b_txt);
        wait_done(FrameCycles + 20);
        check("f2_done_busy", disp.busy, 0);
        step(1);
        check("f3_restart", disp.busy, 1);
        check("f3_pen_off", disp.seg_pen, 0);
        wait_done(FrameCycles + 20);
        step(1);
        check("f3_idle", disp.busy, 0);
        check("f3_queue_empty", exp_q.size(), 0);

        // Forced refresh with same image; a mid-frame update is ignored
        done_base = dones;
        disp.update = 1'b1;
        push_frame(b_txt);
        step(1);
        disp.update = 1'b0;
        check("f4_busy", disp.busy, 1);
        step(50);
        disp.update = 1'b1;
        step(1);
        disp.update = 1'b0;
        wait_done(FrameCycles + 20);
        step(6);
        check("f4_no_extra", disp.busy, 0);
        check("f4_dones", dones - done_base, 1);
        check("f4_queue_empty", exp_q.size(), 0);

        // Reset mid-frame aborts; dirty re-sends the image after release
        disp.seg_txt = c_txt;
        push_frame(c_txt);
        step(1);
        check("f5_busy", disp.busy, 1);
        step(49);
        rst_n = 1'b0;
        step(1);
        check("abort_busy", disp.busy, 0);
        check("abort_pen", disp.seg_pen, 0);
        check("abort_clrn", disp.seg_clrn, 0);
        check("abort_clk", disp.seg_clk, 0);
        exp_q.delete();
        step(2);
        rise_base = rises;
        push_frame(c_txt);
        rst_n = 1'b1;
        step(1);
        check("f6_clrn", disp.seg_clrn, 1);
        check("f6_wait", disp.busy, 0);
        step(1);
        check("f6_busy", disp.busy, 1);
        wait_done(FrameCycles + 20);
        step(1);
        check("f6_rises", rises - rise_base, 64);
        check("f6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
